j_i2s_src: RTL and testbench
============================

# j_i2s_src

I2S master transmitter that drives the serial input side of the Jerry I2S port (`sckin`, `wsin`, `i2rxd`), for example as the CD-side audio source or as a bench stimulus model. Stereo 16-bit sample pairs are buffered in a small FIFO, serialised MSB-first in Philips I2S format, and clocked out with a generated bit clock and word-select. Underruns transmit silence and raise a sticky flag.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in stereo pairs; must be a power of 2 and at least 2.
- `DIVW`, 8: width of the clock-divider input.

Ports:
- `clk`  in  1  system clock; the only clock.
- `resetl`  in  1  asynchronous, active-low reset.
- `din`  in  32  sample pair: left in `[31:16]`, right in `[15:0]`.
- `din_valid`  in  1  a sample pair is offered on `din`.
- `din_ready`  out  1  the FIFO is not full; a push happens on `din_valid & din_ready`.
- `enable`  in  1  run the serialiser.
- `div`  in  DIVW  sets the SCK half-period to `div+1` clk cycles.
- `mode32`  in  1  selects 32-bit slots; this port exists only with `J_I2S_SRC_MODE32_EN`.
- `ur_clr`  in  1  clears `underrun`.
- `sckout`  out  1  bit clock.
- `wsout`  out  1  word select: 0 = left, 1 = right.
- `sdout`  out  1  serial data.
- `frame`  out  1  one-clk pulse at each frame start.
- `underrun`  out  1  sticky underrun flag.
- `level`  out  $clog2(DEPTH)+1  number of pairs held in the FIFO.

## Operation
- Reset values:
  - `sckout`, `wsout`, `sdout`, `frame`, `underrun` are 0.
  - `level` is 0 and `din_ready` is 1.
  - The divider, the position counter `pos` and the shift registers are cleared.
- Slot width N = 16, or N = 32 when `mode32` is set. A frame is 2N bits; `pos` counts 0..2N-1.
- Divider: counter `t` loads `div` and counts down. When `t` reaches 0, `sckout` toggles and `t` reloads `div`. A toggle from 1 to 0 is an "fall event".
- On each fall event `pos` increments and wraps from 2N-1 to 0. Because `ws`, `sd` and `pos` change only on fall events, they are stable across every rising edge.
- `wsout` is 1 for pos in [N-1, 2N-2] and 0 otherwise. This is the I2S one-bit lead of WS before each MSB.
- `sdout` sends the current channel word MSB-first:
  - Slot bit k = pos mod N.
  - k < 16: data bit 15-k.
  - k ≥ 16 (32-bit slots only): 0.
- Frame start: the fall event that wraps `pos` to 0, and the enable rising described below.
  - If the FIFO is non-empty, pop the head: left goes to the shift register, right goes to a holding register that loads the shift register at pos N.
  - If the FIFO is empty, load zeros and set `underrun`.
  - `frame` pulses on the same clk in both cases.
- `underrun` is sticky. `ur_clr` clears it; if an underrun and `ur_clr` occur in the same clk, the set wins.
- FIFO behaviour:
  - A push when full is ignored.
  - A simultaneous push and pop when non-full leaves `level` unchanged.
  - `din_ready` depends on `level` only. It is not combinationally dependent on the pop.
  - Read and write pointers wrap modulo DEPTH.
- Enable low:
  - `sckout`, `wsout`, `sdout` are forced to 0; `t` and `pos` are cleared.
  - FIFO contents and `underrun` are retained; pushes are still accepted.
- Enable rising (idle to run): a frame start is performed in that clk, with a pop or an underrun, `frame` pulse, pos = 0 and `wsout` = 0. `sdout` presents the left MSB from the next clk.
- Enable falling mid-frame: stop immediately. The partial frame is discarded and nothing is re-pushed.
- `div` is sampled at each reload. A mid-run change takes effect after the current half-period.
- `mode32` may change only while `enable` is low; otherwise the behaviour is undefined.

## Timing
- Outputs are registered; no input reaches an output combinationally.
- SCK period is 2·(div+1) clk. With div = 0, `sckout` toggles every clk.
- Frame period is 2N·2·(div+1) clk.
- A push into an empty FIFO during run is transmitted at the next frame start. Minimum latency is 1 clk if the push precedes the frame-start clk.
- `level` and `din_ready` update the clk after the push or pop.
- Asynchronous reset takes effect immediately and is released synchronously.

## Configuration
- `J_I2S_SRC_MODE32_EN` defined: the `mode32` port exists, and 32-bit slots (16 data bits + 16 zeros) are selectable.
- Undefined: no `mode32` port, N is fixed at 16, and `pos` is 5 bits wide.

## Structure
- Shared package `j_i2s_pkg` holds:
  - constants `I2S_SLOT16 = 16` and `I2S_SLOT32 = 32`;
  - the sample-pair typedef (left/right 16-bit fields).
- One sub-module, `j_i2s_fifo`: a synchronous FIFO with `DEPTH`, push/pop, full/empty and level. The serialiser, divider and flags live in the top.

## Test plan
1. Reset with `enable`=1 → all outputs 0 and `level`=0 until `resetl` releases; the first frame then reports an underrun and `sdout` stays 0.
2. Push {16'hA55A, 16'h3C3C}, div=1, enable → SCK period 4 clk; left bits 1010010101011010 appear while ws=0; `wsout` rises one bit before the right MSB; then 0011110000111100 is sent.
3. Push 4 pairs with DEPTH=4 → `din_ready`=0 and a 5th push is ignored; after one frame `level`=3.
4. Empty FIFO for 2 frames → `underrun`=1 and `sdout`=0. Then assert `ur_clr` in the same clk as a new underrun → `underrun` stays 1.
5. Deassert `enable` at pos=7 → outputs go to 0 next clk and `level` is unchanged. Re-enable → a new frame starts with the next FIFO pair.
6. With `J_I2S_SRC_MODE32_EN` and `mode32`=1, push {16'h8001, 16'h0001} → slots are 32 bits, bits 16..31 of each slot are 0, and `wsout` toggles every 32 SCK.

Source files
------------

// File: rtl/j_i2s_pkg.sv
// Shared types and constants for the Jerry-side I2S source.
package j_i2s_pkg;

    localparam int I2S_SLOT16 = 16;
    localparam int I2S_SLOT32 = 32;

    // One stereo sample pair as it sits in the FIFO.
    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } pair_t;

    // Serialiser run state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/j_i2s_fifo.sv
// Small synchronous FIFO of stereo pairs. DEPTH must be a power of two so the
// pointers wrap naturally; full/empty come from the registered level only.
module j_i2s_fifo
    import j_i2s_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetl,
    input  logic                   push,
    input  logic                   pop,
    input  pair_t                  wdata,
    output pair_t                  rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    pair_t          mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/j_i2s_src.sv
// I2S master transmitter feeding the Jerry serial input (sck/ws/data).
// Optional feature macro: J_I2S_SRC_MODE32_EN adds the mode32 port and
// 32-bit slots (16 data bits followed by 16 zeros).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | enable low: sck/ws/sd held at 0, divider and pos cleared
// ST_RUN  | serialising; frame starts on the fall event that wraps pos
module j_i2s_src
    import j_i2s_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DIVW  = 8
) (
    input  logic                   clk,
    input  logic                   resetl,
    input  logic [31:0]            din,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic                   enable,
    input  logic [DIVW-1:0]        div,
`ifdef J_I2S_SRC_MODE32_EN
    input  logic                   mode32,
`endif
    input  logic                   ur_clr,
    output logic                   sckout,
    output logic                   wsout,
    output logic                   sdout,
    output logic                   frame,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);

`ifdef J_I2S_SRC_MODE32_EN
    localparam int POSW = 6;
`else
    localparam int POSW = 5;
`endif

    state_t            state;
    state_t            state_nx;
    logic [DIVW-1:0]   t;
    logic [POSW-1:0]   pos;
    logic [POSW-1:0]   pos_nx;
    logic [POSW-1:0]   pos_last;
    logic [POSW-1:0]   pos_right;
    logic [POSW-1:0]   ws_lo;
    logic [POSW-1:0]   ws_hi;
    logic              data_ok;
    logic [15:0]       sh;
    logic [15:0]       hold;
    logic              tick;
    logic              fall;
    logic              start;
    logic              pop;
    logic              full;
    logic              empty;
    pair_t             head;

    j_i2s_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetl (resetl),
        .push   (din_valid),
        .pop    (pop),
        .wdata  (din),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    assign din_ready = ~full;
    assign pop       = start & ~empty;

    // Slot geometry: last position, right-channel start and the WS-high window
    // (WS leads each MSB by one bit, so it spans N-1 .. 2N-2).
    always_comb begin
        pos_last  = POSW'(2 * I2S_SLOT16 - 1);
        pos_right = POSW'(I2S_SLOT16);
        ws_lo     = POSW'(I2S_SLOT16 - 1);
        ws_hi     = POSW'(2 * I2S_SLOT16 - 2);
        data_ok   = 1'b1;
`ifdef J_I2S_SRC_MODE32_EN
        if (mode32) begin
            pos_last  = POSW'(2 * I2S_SLOT32 - 1);
            pos_right = POSW'(I2S_SLOT32);
            ws_lo     = POSW'(I2S_SLOT32 - 1);
            ws_hi     = POSW'(2 * I2S_SLOT32 - 2);
            data_ok   = ~pos_nx[4];
        end
`endif
    end

    // Next bit position, wrapping at the end of the frame.
    always_comb begin
        pos_nx = (pos == pos_last) ? '0 : pos + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: enable alone moves between idle and run.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (enable)  state_nx = ST_RUN;
            ST_RUN:  if (!enable) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Control decode: fall events and frame starts (enable rising or wrap).
    always_comb begin
        tick  = (t == '0);
        fall  = 1'b0;
        start = 1'b0;
        case (state)
            ST_IDLE: start = enable;
            ST_RUN: begin
                fall  = enable & tick & sckout;
                start = fall & (pos == pos_last);
            end
            default: start = 1'b0;
        endcase
    end

    // Half-period down-counter and bit clock; div is sampled at every reload.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            t      <= '0;
            sckout <= 1'b0;
        end else if (!enable) begin
            t      <= '0;
            sckout <= 1'b0;
        end else if (start) begin
            t      <= div;
            sckout <= 1'b0;
        end else if (tick) begin
            t      <= div;
            sckout <= ~sckout;
        end else begin
            t      <= t - 1'b1;
        end
    end

    // Position, word select and serial data; all change only on fall events
    // so they are stable across every rising SCK edge.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            pos   <= '0;
            wsout <= 1'b0;
            sdout <= 1'b0;
            sh    <= '0;
            hold  <= '0;
        end else if (!enable) begin
            pos   <= '0;
            wsout <= 1'b0;
            sdout <= 1'b0;
        end else if (start) begin
            pos   <= '0;
            wsout <= 1'b0;
            if (!empty) begin
                sh    <= head.left;
                hold  <= head.right;
                sdout <= head.left[15];
            end else begin
                sh    <= '0;
                hold  <= '0;
                sdout <= 1'b0;
            end
        end else if (fall) begin
            pos   <= pos_nx;
            wsout <= (pos_nx >= ws_lo) && (pos_nx <= ws_hi);
            if (pos_nx == pos_right) begin
                sh    <= hold;
                sdout <= hold[15];
            end else begin
                sh    <= {sh[14:0], 1'b0};
                sdout <= data_ok & sh[14];
            end
        end
    end

    // Frame pulse and sticky underrun; a new underrun beats a same-cycle clear.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            frame    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            frame <= start;
            if (start & empty) begin
                underrun <= 1'b1;
            end else if (ur_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_j_i2s_src.sv
// Directed bench for j_i2s_src (DEPTH=4, DIVW=8).
module tb_j_i2s_src;
    import j_i2s_pkg::*;

    logic        clk;
    logic        resetl;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        enable;
    logic [7:0]  div;
`ifdef J_I2S_SRC_MODE32_EN
    logic        mode32;
`endif
    logic        ur_clr;
    logic        sckout;
    logic        wsout;
    logic        sdout;
    logic        frame;
    logic        underrun;
    logic [2:0]  level;

    int total;
    int bad;

    j_i2s_src #(.DEPTH(4), .DIVW(8)) dut (
        .clk       (clk),
        .resetl    (resetl),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .enable    (enable),
        .div       (div),
`ifdef J_I2S_SRC_MODE32_EN
        .mode32    (mode32),
`endif
        .ur_clr    (ur_clr),
        .sckout    (sckout),
        .wsout     (wsout),
        .sdout     (sdout),
        .frame     (frame),
        .underrun  (underrun),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; one push offered for one clk.
    task automatic push(input logic [31:0] v);
        din       = v;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // Wait for a frame pulse, then record sd/ws on each of nbits rising SCK edges.
    task automatic capture(input int nbits, output logic [63:0] sdb,
                           output logic [63:0] wsb, output int period, output bit ok);
        int   n;
        int   cyc;
        int   r0;
        int   wc;
        logic prev;
        sdb = '0; wsb = '0; period = 0; ok = 1'b0;
        n = 0; cyc = 0; r0 = 0; wc = 0;
        do begin
            @(negedge clk);
            wc++;
        end while (frame !== 1'b1 && wc < 1000);
        if (frame !== 1'b1) return;
        prev = sckout;
        while (n < nbits && cyc < nbits * 20) begin
            @(negedge clk);
            cyc++;
            if (prev === 1'b0 && sckout === 1'b1) begin
                sdb = {sdb[62:0], sdout};
                wsb = {wsb[62:0], wsout};
                if (n == 0) r0 = cyc;
                else if (n == 1) period = cyc - r0;
                n++;
            end
            prev = sckout;
        end
        ok = (n == nbits);
    endtask

    task automatic test_reset;
        logic [63:0] sdb, wsb;
        int          per;
        bit          ok;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({sckout, wsout, sdout, frame, underrun} !== 5'b0) begin bad++;
            $display("FAIL reset_outs got=%b exp=00000", {sckout, wsout, sdout, frame, underrun}); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", din_ready); end
        resetl = 1'b1;
        capture(32, sdb, wsb, per, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL reset_capture got=%b exp=1", ok); end
        total++; if (sdb[31:0] !== 32'h0) begin bad++; $display("FAIL reset_silence got=%h exp=0", sdb[31:0]); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL reset_underrun got=%b exp=1", underrun); end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_serial;
        logic [63:0] sdb, wsb;
        int          per;
        bit          ok;
        ur_clr = 1'b1;
        @(negedge clk);
        ur_clr = 1'b0;
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_clr got=%b exp=0", underrun); end
        push(32'hA55A_3C3C);
        total++; if (level !== 3'd1) begin bad++; $display("FAIL push_level got=%0d exp=1", level); end
        enable = 1'b1;
        capture(32, sdb, wsb, per, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ser_capture got=%b exp=1", ok); end
        total++; if (sdb[31:0] !== 32'hA55A_3C3C) begin bad++; $display("FAIL ser_data got=%h exp=a55a3c3c", sdb[31:0]); end
        total++; if (wsb[31:0] !== 32'h0001_FFFE) begin bad++; $display("FAIL ser_ws got=%h exp=0001fffe", wsb[31:0]); end
        total++; if (per !== 4) begin bad++; $display("FAIL ser_period got=%0d exp=4", per); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ser_no_ur got=%b exp=0", underrun); end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_and_stop;
        logic [63:0] sdb, wsb;
        int          per;
        bit          ok;
        int          falls;
        int          wc;
        logic        prev;
        ur_clr = 1'b1;
        @(negedge clk);
        ur_clr = 1'b0;
        push(32'hA5A5_0F0F);
        push(32'h1234_5678);
        push(32'hFFFF_0001);
        push(32'h8000_7FFE);
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", din_ready); end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", level); end
        push(32'hDEAD_BEEF);
        total++; if (level !== 3'd4) begin bad++; $display("FAIL overflow_level got=%0d exp=4", level); end
        enable = 1'b1;
        capture(32, sdb, wsb, per, ok);
        total++; if (sdb[31:0] !== 32'hA5A5_0F0F || ok !== 1'b1) begin bad++; $display("FAIL pair0 got=%h exp=a5a50f0f", sdb[31:0]); end
        total++; if (level !== 3'd3) begin bad++; $display("FAIL level_after_frame got=%0d exp=3", level); end
        capture(32, sdb, wsb, per, ok);
        total++; if (sdb[31:0] !== 32'h1234_5678 || ok !== 1'b1) begin bad++; $display("FAIL pair1 got=%h exp=12345678", sdb[31:0]); end
        total++; if (level !== 3'd2) begin bad++; $display("FAIL level_pair1 got=%0d exp=2", level); end
        // Abort the third frame while pos=7 and sck is high.
        wc = 0;
        do begin @(negedge clk); wc++; end while (frame !== 1'b1 && wc < 1000);
        falls = 0;
        prev  = sckout;
        while (falls < 7 && wc < 2000) begin
            @(negedge clk); wc++;
            if (prev === 1'b1 && sckout === 1'b0) falls++;
            prev = sckout;
        end
        while (sckout !== 1'b1 && wc < 2000) begin @(negedge clk); wc++; end
        total++; if (wc >= 2000) begin bad++; $display("FAIL stop_timeout got=%0d exp<2000", wc); end
        total++; if ({sckout, wsout, sdout} !== 3'b101) begin bad++; $display("FAIL pos7_outs got=%b exp=101", {sckout, wsout, sdout}); end
        enable = 1'b0;
        @(negedge clk);
        total++; if ({sckout, wsout, sdout} !== 3'b000) begin bad++; $display("FAIL stop_outs got=%b exp=000", {sckout, wsout, sdout}); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL stop_level got=%0d exp=1", level); end
        enable = 1'b1;
        capture(32, sdb, wsb, per, ok);
        total++; if (sdb[31:0] !== 32'h8000_7FFE || ok !== 1'b1) begin bad++; $display("FAIL pair3 got=%h exp=80007ffe", sdb[31:0]); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL level_pair3 got=%0d exp=0", level); end
    endtask

    task automatic test_underrun;
        logic [63:0] sdb, wsb;
        int          per;
        bit          ok;
        for (int i = 0; i < 2; i++) begin
            capture(32, sdb, wsb, per, ok);
            total++; if (sdb[31:0] !== 32'h0 || ok !== 1'b1) begin bad++; $display("FAIL ur_silence%0d got=%h exp=0", i, sdb[31:0]); end
            total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_flag%0d got=%b exp=1", i, underrun); end
        end
        enable = 1'b0;
        ur_clr = 1'b1;
        @(negedge clk);
        ur_clr = 1'b0;
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_cleared got=%b exp=0", underrun); end
        enable = 1'b1;
        ur_clr = 1'b1;
        @(negedge clk);
        ur_clr = 1'b0;
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set_wins got=%b exp=1", underrun); end
        total++; if (frame !== 1'b1) begin bad++; $display("FAIL ur_frame got=%b exp=1", frame); end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div0;
        logic [63:0] sdb, wsb;
        int          per;
        bit          ok;
        div = 8'd0;
        push(32'h1234_FEDC);
        enable = 1'b1;
        capture(32, sdb, wsb, per, ok);
        total++; if (per !== 2) begin bad++; $display("FAIL div0_period got=%0d exp=2", per); end
        total++; if (sdb[31:0] !== 32'h1234_FEDC || ok !== 1'b1) begin bad++; $display("FAIL div0_data got=%h exp=1234fedc", sdb[31:0]); end
        total++; if (wsb[31:0] !== 32'h0001_FFFE) begin bad++; $display("FAIL div0_ws got=%h exp=0001fffe", wsb[31:0]); end
        enable = 1'b0;
        div    = 8'd1;
        @(negedge clk);
    endtask

`ifdef J_I2S_SRC_MODE32_EN
    task automatic test_mode32;
        logic [63:0] sdb, wsb;
        int          per;
        bit          ok;
        mode32 = 1'b1;
        push(32'h8001_0001);
        enable = 1'b1;
        capture(64, sdb, wsb, per, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL m32_capture got=%b exp=1", ok); end
        total++; if (sdb !== 64'h8001_0000_0001_0000) begin bad++; $display("FAIL m32_data got=%h exp=8001000000010000", sdb); end
        total++; if (wsb !== 64'h0000_0001_FFFF_FFFE) begin bad++; $display("FAIL m32_ws got=%h exp=00000001fffffffe", wsb); end
        total++; if (per !== 4) begin bad++; $display("FAIL m32_period got=%0d exp=4", per); end
        enable = 1'b0;
        @(negedge clk);
        mode32 = 1'b0;
    endtask
`endif

    initial begin
        total     = 0;
        bad       = 0;
        resetl    = 1'b0;
        enable    = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        div       = 8'd1;
        ur_clr    = 1'b0;
`ifdef J_I2S_SRC_MODE32_EN
        mode32    = 1'b0;
`endif
        test_reset;
        test_serial;
        test_full_and_stop;
        test_underrun;
        test_div0;
`ifdef J_I2S_SRC_MODE32_EN
        test_mode32;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
